// File: rtl/sr_mem_bridge_pkg.sv
// Shared types and AXI constants for the schoolRISCV memory-to-AXI bridge.
package sr_mem_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      WR_ADDR_DATA = 3'd1,
      WR_RESP      = 3'd2,
      RD_ADDR      = 3'd3,
      RD_DATA      = 3'd4,
      RESP         = 3'd5
   } state_e;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

endpackage

// File: rtl/sr_mem_axi_bridge_if.sv
// AXI4 channel bundle between the bridge (master) and the NoC network interface (slave).
interface sr_mem_axi_bridge_if #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32
);
   logic [ID_W-1:0]   awid;
   logic [ADDR_W-1:0] awaddr;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              awvalid;
   logic              awready;

   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wlast;
   logic              wvalid;
   logic              wready;

   logic [ID_W-1:0]   bid;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;

   logic [ID_W-1:0]   arid;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arvalid;
   logic              arready;

   logic [ID_W-1:0]   rid;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/sr_sat_counter.sv
// Saturating up-counter: holds at all-ones, clears on rst or clear.
module sr_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q, cnt_d;

   // Next count: clear wins, increments stop at the top value.
   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (inc && (cnt_q != {W{1'b1}}))
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/sr_mem_axi_bridge.sv
// schoolRISCV data-memory port to single-beat AXI4 master, one transaction in flight.
// Optional feature macro: SR_MEM_BRIDGE_ERR_EN makes err_o / err_cnt_o live;
// without it both are tied to zero and no counter is built.
module sr_mem_axi_bridge
   import sr_mem_bridge_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                ID_W      = 4,
   parameter logic [ID_W-1:0]   AXI_ID    = '0,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_wr_i,
   input  logic [15:0] mem_addr_i,
   input  logic        mem_req_valid_i,
   output logic        mem_req_ready_o,
   input  logic [31:0] mem_wdata_i,
   output logic        mem_resp_valid_o,
   input  logic        mem_resp_ready_i,
   output logic [31:0] mem_rdata_o,
   sr_mem_axi_bridge_if.master axi,
   output logic        err_o,
   output logic [7:0]  err_cnt_o
);
   state_e            state_q, state_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;

   // Next state and write-channel completion flags.
   always_comb begin
      state_d   = state_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      case (state_q)
         IDLE: begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (mem_req_valid_i)
               state_d = mem_wr_i ? WR_ADDR_DATA : RD_ADDR;
         end
         WR_ADDR_DATA: begin
            if (axi.awready) aw_done_d = 1'b1;
            if (axi.wready)  w_done_d  = 1'b1;
            if (aw_done_d && w_done_d) begin
               state_d   = WR_RESP;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         WR_RESP: if (axi.bvalid)       state_d = RESP;
         RD_ADDR: if (axi.arready)      state_d = RD_DATA;
         RD_DATA: if (axi.rvalid)       state_d = RESP;
         RESP:    if (mem_resp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // Request capture (word-aligned, rebased) and read-data capture.
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      if (state_q == IDLE && mem_req_valid_i) begin
         addr_d  = BASE_ADDR + {{(ADDR_W-16){1'b0}}, mem_addr_i[15:2], 2'b00};
         wdata_d = mem_wdata_i;
      end
      if (state_q == RD_DATA && axi.rvalid)
         rdata_d = axi.rdata;
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Handshake outputs decoded purely from state, so no AXI input reaches the core combinationally.
   always_comb begin
      mem_req_ready_o  = (state_q == IDLE);
      mem_resp_valid_o = (state_q == RESP);
      axi.awvalid      = (state_q == WR_ADDR_DATA) && !aw_done_q;
      axi.wvalid       = (state_q == WR_ADDR_DATA) && !w_done_q;
      axi.bready       = (state_q == WR_RESP);
      axi.arvalid      = (state_q == RD_ADDR);
      axi.rready       = (state_q == RD_DATA);
   end

   assign mem_rdata_o = rdata_q;

   assign axi.awid    = AXI_ID;
   assign axi.awaddr  = addr_q;
   assign axi.awlen   = 8'd0;
   assign axi.awsize  = AXI_SIZE_4B;
   assign axi.awburst = AXI_BURST_INCR;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = 4'hF;
   assign axi.wlast   = 1'b1;
   assign axi.arid    = AXI_ID;
   assign axi.araddr  = addr_q;
   assign axi.arlen   = 8'd0;
   assign axi.arsize  = AXI_SIZE_4B;
   assign axi.arburst = AXI_BURST_INCR;

   // IDs and rlast carry no information with a single transaction in flight.
   wire unused_ids = &{1'b0, axi.bid, axi.rid, axi.rlast};

`ifdef SR_MEM_BRIDGE_ERR_EN
   logic err_event;
   logic err_q, err_d;

   // Non-OKAY response seen on an accepted B or R beat.
   always_comb begin
      err_event = ((state_q == WR_RESP) && axi.bvalid && (axi.bresp != AXI_RESP_OKAY)) ||
                  ((state_q == RD_DATA) && axi.rvalid && (axi.rresp != AXI_RESP_OKAY));
      err_d     = err_q | err_event;
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   sr_sat_counter #(.W(8)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (1'b0),
      .inc   (err_event),
      .cnt_o (err_cnt_o)
   );

   assign err_o = err_q;
`else
   assign err_o     = 1'b0;
   assign err_cnt_o = 8'd0;

   wire unused_resp = &{1'b0, axi.bresp, axi.rresp};
`endif

endmodule

// File: tb/tb_sr_mem_axi_bridge.sv
// Directed self-checking bench for sr_mem_axi_bridge (BASE_ADDR = 0x8000_0000).
module tb_sr_mem_axi_bridge;
   logic        clk = 1'b0;
   logic        rst;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_wdata;
   logic        mem_resp_valid;
   logic        mem_resp_ready;
   logic [31:0] mem_rdata;
   logic        err;
   logic [7:0]  err_cnt;

   int checks = 0;
   int errors = 0;

   sr_mem_axi_bridge_if #(.ID_W(4), .ADDR_W(32)) axi_if ();

   sr_mem_axi_bridge #(
      .ADDR_W    (32),
      .ID_W      (4),
      .AXI_ID    (4'd0),
      .BASE_ADDR (32'h8000_0000)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .mem_wr_i         (mem_wr),
      .mem_addr_i       (mem_addr),
      .mem_req_valid_i  (mem_req_valid),
      .mem_req_ready_o  (mem_req_ready),
      .mem_wdata_i      (mem_wdata),
      .mem_resp_valid_o (mem_resp_valid),
      .mem_resp_ready_i (mem_resp_ready),
      .mem_rdata_o      (mem_rdata),
      .axi              (axi_if.master),
      .err_o            (err),
      .err_cnt_o        (err_cnt)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (mem_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", mem_req_ready); end
      checks++; if (mem_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", mem_resp_valid); end
      checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", mem_rdata); end
      checks++; if ({axi_if.awvalid, axi_if.wvalid, axi_if.bready, axi_if.arvalid, axi_if.rready} !== 5'b0) begin
         errors++; $display("FAIL reset_axi_valids: got %b expected 00000",
            {axi_if.awvalid, axi_if.wvalid, axi_if.bready, axi_if.arvalid, axi_if.rready});
      end
      checks++; if ({err, err_cnt} !== 9'h0) begin errors++; $display("FAIL reset_err: got %b/%h expected 0/00", err, err_cnt); end
      $display("reset: done");
   endtask

   task automatic test_load_zero_wait();
      mem_wr = 1'b0; mem_addr = 16'h0104; mem_req_valid = 1'b1;
      tick();                                  // T+1
      mem_req_valid = 1'b0;
      checks++; if (axi_if.arvalid !== 1'b1) begin errors++; $display("FAIL load_arvalid: got %b expected 1", axi_if.arvalid); end
      checks++; if (axi_if.araddr !== 32'h8000_0104) begin errors++; $display("FAIL load_araddr: got %h expected 80000104", axi_if.araddr); end
      checks++; if ({axi_if.arlen, axi_if.arsize, axi_if.arburst, axi_if.arid} !== {8'd0, 3'b010, 2'b01, 4'd0}) begin
         errors++; $display("FAIL load_ar_fields: got %h expected %h",
            {axi_if.arlen, axi_if.arsize, axi_if.arburst, axi_if.arid}, {8'd0, 3'b010, 2'b01, 4'd0});
      end
      checks++; if (mem_req_ready !== 1'b0) begin errors++; $display("FAIL load_req_ready_busy: got %b expected 0", mem_req_ready); end
      axi_if.arready = 1'b1;
      tick();                                  // T+2
      axi_if.arready = 1'b0;
      checks++; if ({axi_if.arvalid, axi_if.rready, mem_resp_valid} !== 3'b010) begin
         errors++; $display("FAIL load_t2: got arvalid,rready,resp=%b expected 010", {axi_if.arvalid, axi_if.rready, mem_resp_valid});
      end
      axi_if.rvalid = 1'b1; axi_if.rdata = 32'hCAFE_0001; axi_if.rresp = 2'b00;
      tick();                                  // T+3
      axi_if.rvalid = 1'b0;
      checks++; if (mem_resp_valid !== 1'b1) begin errors++; $display("FAIL load_resp_t3: got %b expected 1", mem_resp_valid); end
      checks++; if (mem_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL load_rdata: got %h expected cafe0001", mem_rdata); end
      tick();                                  // T+4
      checks++; if ({mem_resp_valid, mem_req_ready} !== 2'b01) begin
         errors++; $display("FAIL load_t4: got resp,req_ready=%b expected 01", {mem_resp_valid, mem_req_ready});
      end
      $display("load 0104: araddr=%h rdata=%h", 32'h8000_0104, mem_rdata);
   endtask

   task automatic test_store_aw_delay();
      int aw_cycles = 0;
      mem_wr = 1'b1; mem_addr = 16'h0040; mem_wdata = 32'h1234_5678; mem_req_valid = 1'b1;
      tick();                                  // T+1
      mem_req_valid = 1'b0;
      checks++; if ({axi_if.awvalid, axi_if.wvalid} !== 2'b11) begin
         errors++; $display("FAIL store_valids_t1: got %b expected 11", {axi_if.awvalid, axi_if.wvalid});
      end
      checks++; if ({axi_if.awaddr, axi_if.wdata, axi_if.wstrb, axi_if.wlast} !== {32'h8000_0040, 32'h1234_5678, 4'hF, 1'b1}) begin
         errors++; $display("FAIL store_fields: got %h/%h/%h/%b expected 80000040/12345678/f/1",
            axi_if.awaddr, axi_if.wdata, axi_if.wstrb, axi_if.wlast);
      end
      axi_if.wready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (axi_if.awvalid !== 1'b1) break;
         aw_cycles++;
         if (i == 1) begin
            checks++; if (axi_if.wvalid !== 1'b0) begin errors++; $display("FAIL store_wvalid_drop: got %b expected 0", axi_if.wvalid); end
         end
         axi_if.awready = (aw_cycles == 4);
         tick();
         axi_if.wready = 1'b0;
      end
      axi_if.awready = 1'b0;
      checks++; if (aw_cycles !== 4) begin errors++; $display("FAIL store_aw_cycles: got %0d expected 4", aw_cycles); end
      checks++; if ({axi_if.bready, mem_resp_valid} !== 2'b10) begin
         errors++; $display("FAIL store_bready: got bready,resp=%b expected 10", {axi_if.bready, mem_resp_valid});
      end
      axi_if.bvalid = 1'b1; axi_if.bresp = 2'b00;
      tick();
      axi_if.bvalid = 1'b0;
      checks++; if ({mem_resp_valid, axi_if.bready} !== 2'b10) begin
         errors++; $display("FAIL store_resp: got resp,bready=%b expected 10", {mem_resp_valid, axi_if.bready});
      end
      checks++; if (mem_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL store_rdata_kept: got %h expected cafe0001", mem_rdata); end
      tick();
      checks++; if ({mem_resp_valid, mem_req_ready} !== 2'b01) begin
         errors++; $display("FAIL store_done: got resp,req_ready=%b expected 01", {mem_resp_valid, mem_req_ready});
      end
      $display("store 0040: awvalid cycles=%0d", aw_cycles);
   endtask

   task automatic test_load_slow();
      int resp_cycles = 0;
      mem_wr = 1'b0; mem_addr = 16'h0200; mem_req_valid = 1'b1;
      tick();
      mem_req_valid = 1'b0;
      axi_if.arready = 1'b1;
      tick();
      axi_if.arready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checks++; if ({mem_req_ready, axi_if.rready} !== 2'b01) begin
            errors++; $display("FAIL slow_wait_%0d: got req_ready,rready=%b expected 01", i, {mem_req_ready, axi_if.rready});
         end
         tick();
      end
      axi_if.rvalid = 1'b1; axi_if.rdata = 32'hDEAD_BEEF; axi_if.rresp = 2'b00;
      mem_resp_ready = 1'b0;
      tick();
      axi_if.rvalid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (mem_resp_valid !== 1'b1) break;
         resp_cycles++;
         checks++; if (mem_req_ready !== 1'b0) begin errors++; $display("FAIL slow_req_ready_resp: got %b expected 0", mem_req_ready); end
         mem_resp_ready = (resp_cycles == 3);
         tick();
      end
      mem_resp_ready = 1'b1;
      checks++; if (resp_cycles !== 3) begin errors++; $display("FAIL slow_resp_cycles: got %0d expected 3", resp_cycles); end
      checks++; if ({mem_req_ready, mem_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
         errors++; $display("FAIL slow_end: got req_ready=%b rdata=%h expected 1/deadbeef", mem_req_ready, mem_rdata);
      end
      $display("slow load 0200: resp cycles=%0d rdata=%h", resp_cycles, mem_rdata);
   endtask

   task automatic test_errors();
      logic       exp_err;
      logic [7:0] exp_cnt;
`ifdef SR_MEM_BRIDGE_ERR_EN
      exp_err = 1'b1; exp_cnt = 8'd2;
`else
      exp_err = 1'b0; exp_cnt = 8'd0;
`endif
      // Load with SLVERR
      mem_wr = 1'b0; mem_addr = 16'h0010; mem_req_valid = 1'b1;
      tick(); mem_req_valid = 1'b0; axi_if.arready = 1'b1;
      tick(); axi_if.arready = 1'b0;
      axi_if.rvalid = 1'b1; axi_if.rdata = 32'h1111_2222; axi_if.rresp = 2'b10;
      tick(); axi_if.rvalid = 1'b0; axi_if.rresp = 2'b00;
      checks++; if ({mem_resp_valid, mem_rdata} !== {1'b1, 32'h1111_2222}) begin
         errors++; $display("FAIL err_load: got resp=%b rdata=%h expected 1/11112222", mem_resp_valid, mem_rdata);
      end
      tick();
      // Store with DECERR
      mem_wr = 1'b1; mem_addr = 16'h0020; mem_wdata = 32'h0; mem_req_valid = 1'b1;
      tick(); mem_req_valid = 1'b0; axi_if.awready = 1'b1; axi_if.wready = 1'b1;
      tick(); axi_if.awready = 1'b0; axi_if.wready = 1'b0;
      axi_if.bvalid = 1'b1; axi_if.bresp = 2'b11;
      tick(); axi_if.bvalid = 1'b0; axi_if.bresp = 2'b00;
      checks++; if (mem_resp_valid !== 1'b1) begin errors++; $display("FAIL err_store_resp: got %b expected 1", mem_resp_valid); end
      tick();
      checks++; if (err !== exp_err) begin errors++; $display("FAIL err_flag: got %b expected %b", err, exp_err); end
      checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL err_cnt: got %0d expected %0d", err_cnt, exp_cnt); end
      $display("errors: err=%b err_cnt=%0d", err, err_cnt);
   endtask

   task automatic test_reset_mid_and_misaligned();
      mem_wr = 1'b0; mem_addr = 16'h0100; mem_req_valid = 1'b1;
      tick(); mem_req_valid = 1'b0; axi_if.arready = 1'b1;
      tick(); axi_if.arready = 1'b0;
      checks++; if (axi_if.rready !== 1'b1) begin errors++; $display("FAIL mid_rd_data: got rready=%b expected 1", axi_if.rready); end
      rst = 1'b1;
      axi_if.rvalid = 1'b1; axi_if.rdata = 32'hBAD0_BAD0;
      tick();
      rst = 1'b0;
      checks++; if ({axi_if.arvalid, axi_if.rready, mem_req_ready} !== 3'b001) begin
         errors++; $display("FAIL mid_after_rst: got arvalid,rready,req_ready=%b expected 001",
            {axi_if.arvalid, axi_if.rready, mem_req_ready});
      end
      tick();
      checks++; if ({axi_if.rready, mem_resp_valid, mem_rdata} !== {2'b00, 32'h0}) begin
         errors++; $display("FAIL mid_stale_r: got rready=%b resp=%b rdata=%h expected 0/0/00000000",
            axi_if.rready, mem_resp_valid, mem_rdata);
      end
      checks++; if ({err, err_cnt} !== 9'h0) begin errors++; $display("FAIL mid_err_cleared: got %b/%h expected 0/00", err, err_cnt); end
      axi_if.rvalid = 1'b0;
      // Misaligned follow-up load
      mem_addr = 16'h0007; mem_req_valid = 1'b1;
      tick(); mem_req_valid = 1'b0;
      checks++; if (axi_if.araddr !== 32'h8000_0004) begin errors++; $display("FAIL misaligned_araddr: got %h expected 80000004", axi_if.araddr); end
      axi_if.arready = 1'b1;
      tick(); axi_if.arready = 1'b0;
      axi_if.rvalid = 1'b1; axi_if.rdata = 32'h0BAD_F00D; axi_if.rresp = 2'b00;
      tick(); axi_if.rvalid = 1'b0;
      checks++; if ({mem_resp_valid, mem_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
         errors++; $display("FAIL post_reset_load: got resp=%b rdata=%h expected 1/0badf00d", mem_resp_valid, mem_rdata);
      end
      tick();
      $display("reset mid-read + misaligned load 0007: rdata=%h", mem_rdata);
   endtask

   initial begin
      rst = 1'b1;
      mem_wr = 1'b0; mem_addr = 16'h0; mem_req_valid = 1'b0; mem_wdata = 32'h0; mem_resp_ready = 1'b1;
      axi_if.awready = 1'b0; axi_if.wready = 1'b0;
      axi_if.bid = 4'd0; axi_if.bresp = 2'b00; axi_if.bvalid = 1'b0;
      axi_if.arready = 1'b0;
      axi_if.rid = 4'd0; axi_if.rdata = 32'h0; axi_if.rresp = 2'b00; axi_if.rlast = 1'b1; axi_if.rvalid = 1'b0;

      test_reset();
      test_load_zero_wait();
      test_store_aw_delay();
      test_load_slow();
      test_errors();
      test_reset_mid_and_misaligned();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
